state_sel_pipe: RTL

STATE_SEL_PIPE -- requirements
Module: state_sel_pipe

---
 rtl/aes_mux_pkg.sv | 13 +
 rtl/state_sel_fifo2.sv | 79 +++++++
 rtl/state_sel_pipe.sv | 96 +++++++++
 3 files changed

// File: rtl/aes_mux_pkg.sv
// Shared constants for the state_sel_pipe channel selector.
package aes_mux_pkg;

  localparam int MODE_SEL      = 0;
  localparam int MODE_RR       = 1;
  localparam int DEFAULT_WIDTH = 128;

  // Index width for n channels, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/state_sel_fifo2.sv
// Two-entry output buffer of {data, index}; the head entry drives the outputs.
module state_sel_fifo2
  import aes_mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic [IDX_W-1:0] push_idx_i,
  input  logic             pop_ready_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic [IDX_W-1:0] head_idx_o,
  output logic             head_valid_o,
  output logic [1:0]       count_o
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [IDX_W-1:0] idx;
  } entry_t;

  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  logic [1:0] count_q, count_d;
  logic       pop;
  entry_t     new_e;

  assign new_e        = '{data: push_data_i, idx: push_idx_i};
  assign pop          = (count_q != 2'd0) && pop_ready_i;
  assign head_data_o  = head_q.data;
  assign head_idx_o   = head_q.idx;
  assign head_valid_o = (count_q != 2'd0);
  assign count_o      = count_q;

  // Next head/tail/count from the push/pop combination of this edge.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({push_i, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = new_e;
        else                 tail_d = new_e;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Pop and push together: the new beat lands behind whatever remains.
        if (count_q == 2'd1) begin
          head_d = new_e;
        end else begin
          head_d = tail_q;
          tail_d = new_e;
        end
      end
      default: ;
    endcase
  end

  // Buffer state registers; reset discards any held entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/state_sel_pipe.sv
// N-to-1 channel selector (explicit select or round-robin) feeding a 2-entry buffer.
module state_sel_pipe
  import aes_mux_pkg::*;
#(
  parameter  int WIDTH  = DEFAULT_WIDTH,
  parameter  int NUM_IN = 8,
  parameter  int MODE   = MODE_SEL,
  localparam int SEL_W  = idx_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  logic [SEL_W-1:0] last_q;
  logic             sel_err_q;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_vld;
  logic             sel_bad;
  logic             accept_ok;
  logic             push;
  logic [1:0]       count;
  logic [WIDTH-1:0] push_data;

  // Acceptance depends only on registered occupancy, so out_ready never reaches in_ready.
  assign accept_ok = (count < 2'd2);

  // Grant selection and per-channel ready.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    sel_bad   = 1'b0;
    in_ready  = '0;
    if (MODE == MODE_RR) begin
      for (int unsigned off = 1; off <= NUM_IN; off++) begin
        int unsigned idx;
        idx = (32'(last_q) + off) % NUM_IN;
        if (!grant_vld && in_valid[idx]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(idx);
        end
      end
      if (grant_vld) in_ready[grant_idx] = accept_ok;
    end else begin
      if (32'(sel) < NUM_IN) begin
        grant_idx      = sel;
        grant_vld      = in_valid[sel];
        in_ready[sel]  = accept_ok;
      end else begin
        sel_bad = 1'b1;
      end
    end
    if (rst) in_ready = '0;
  end

  assign push      = grant_vld && in_ready[grant_idx];
  assign push_data = in_data[32'(grant_idx)*WIDTH +: WIDTH];

  // Round-robin pointer and select-error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= SEL_W'(NUM_IN - 1);
      sel_err_q <= 1'b0;
    end else begin
      if (push) last_q <= grant_idx;
      sel_err_q <= (MODE == MODE_SEL) && sel_bad && (|in_valid);
    end
  end

  assign sel_err = sel_err_q;

  state_sel_fifo2 #(
    .WIDTH (WIDTH),
    .IDX_W (SEL_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_data_i  (push_data),
    .push_idx_i   (grant_idx),
    .pop_ready_i  (out_ready),
    .head_data_o  (out_data),
    .head_idx_o   (out_sel),
    .head_valid_o (out_valid),
    .count_o      (count)
  );

endmodule
